// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the countdown controller: FSM state codes, BCD widths
// and a helper that builds an MM:SS BCD word from binary minutes/seconds.
package countdown_ctrl_pkg;

    localparam int BCD_W  = 4;
    localparam int TIME_W = 4 * BCD_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    function automatic logic [TIME_W-1:0] to_bcd(input int mins, input int secs);
        return {BCD_W'(mins / 10), BCD_W'(mins % 10), BCD_W'(secs / 10), BCD_W'(secs % 10)};
    endfunction

endpackage

// File: rtl/bcd_mmss_cnt.sv
// Loadable four-digit MM:SS BCD register with decrement, minute/second increment
// (each wrapping 59 -> 00) and a zero flag on the value it will hold next edge.
module bcd_mmss_cnt
    import countdown_ctrl_pkg::*;
#(
    parameter logic [TIME_W-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [TIME_W-1:0] i_load_val,
    input  logic              i_dec,
    input  logic              i_inc_min,
    input  logic              i_inc_sec,
    output logic [TIME_W-1:0] o_val,
    output logic              o_zero_nxt
);

    logic [TIME_W-1:0] r_val;
    logic [TIME_W-1:0] w_nxt;
    logic [BCD_W-1:0]  w_mt, w_mu, w_st, w_su;

    assign w_mt = r_val[15:12];
    assign w_mu = r_val[11:8];
    assign w_st = r_val[7:4];
    assign w_su = r_val[3:0];

    // Priority: load > decrement > minute increment > second increment.
    always_comb begin
        w_nxt = r_val;
        if (i_load) begin
            w_nxt = i_load_val;
        end else if (i_dec) begin
            if (r_val == '0) begin
                w_nxt = r_val;
            end else if (w_su != 4'd0) begin
                w_nxt[3:0] = w_su - 4'd1;
            end else begin
                w_nxt[3:0] = 4'd9;
                if (w_st != 4'd0) begin
                    w_nxt[7:4] = w_st - 4'd1;
                end else begin
                    w_nxt[7:4] = 4'd5;
                    if (w_mu != 4'd0) begin
                        w_nxt[11:8] = w_mu - 4'd1;
                    end else begin
                        w_nxt[11:8]  = 4'd9;
                        w_nxt[15:12] = w_mt - 4'd1;
                    end
                end
            end
        end else if (i_inc_min) begin
            if (w_mu == 4'd9) begin
                w_nxt[11:8]  = 4'd0;
                w_nxt[15:12] = (w_mt == 4'd5) ? 4'd0 : w_mt + 4'd1;
            end else begin
                w_nxt[11:8] = w_mu + 4'd1;
            end
        end else if (i_inc_sec) begin
            if (w_su == 4'd9) begin
                w_nxt[3:0] = 4'd0;
                w_nxt[7:4] = (w_st == 4'd5) ? 4'd0 : w_st + 4'd1;
            end else begin
                w_nxt[3:0] = w_su + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_val <= RST_VAL;
        end else begin
            r_val <= w_nxt;
        end
    end

    assign o_val      = r_val;
    assign o_zero_nxt = (w_nxt == '0);

endmodule

// File: rtl/countdown_ctrl.sv
// MM:SS countdown timer controller with preset editing, pause and expiry alarm.
// Define COUNTDOWN_CTRL_BLINK_EN to blink display digits in edit/pause/done states.
module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int DEFAULT_MIN = 1,
    parameter int DEFAULT_SEC = 0,
    parameter int ALARM_TICKS = 10
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        TICK,
    input  logic        BTN_START,
    input  logic        BTN_STOP,
    input  logic        BTN_SET,
    input  logic        BTN_INC,
    output logic [15:0] TIME_BCD,
    output logic [3:0]  DIG_EN,
    output logic [2:0]  STATE,
    output logic        ALARM
);

    localparam logic [TIME_W-1:0] PRESET_RST = to_bcd(DEFAULT_MIN, DEFAULT_SEC);
    localparam logic [7:0]        ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t            r_state, w_state_nxt;
    logic              r_alarm;
    logic [7:0]        r_alarm_cnt;
    logic              w_stop, w_start, w_set, w_inc;
    logic              w_cnt_load, w_cnt_dec, w_inc_min, w_inc_sec;
    logic [TIME_W-1:0] w_preset, w_cnt;
    logic              w_preset_zero, w_cnt_zero;

    // Only the highest-priority button pressed in a cycle is seen at all.
    assign w_stop  = BTN_STOP;
    assign w_start = BTN_START & ~BTN_STOP;
    assign w_set   = BTN_SET & ~BTN_STOP & ~BTN_START;
    assign w_inc   = BTN_INC & ~BTN_STOP & ~BTN_START & ~BTN_SET;

    assign w_cnt_load = (r_state == ST_IDLE) & w_start & ~w_preset_zero;
    assign w_cnt_dec  = (r_state == ST_RUN) & TICK & ~w_stop;
    assign w_inc_min  = (r_state == ST_SET_MIN) & w_inc;
    assign w_inc_sec  = (r_state == ST_SET_SEC) & w_inc;

    bcd_mmss_cnt #(.RST_VAL(PRESET_RST)) u_preset (
        .i_clk      (CLK),
        .i_rst_n    (CLR),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_dec      (1'b0),
        .i_inc_min  (w_inc_min),
        .i_inc_sec  (w_inc_sec),
        .o_val      (w_preset),
        .o_zero_nxt (w_preset_zero)
    );

    bcd_mmss_cnt #(.RST_VAL(PRESET_RST)) u_cnt (
        .i_clk      (CLK),
        .i_rst_n    (CLR),
        .i_load     (w_cnt_load),
        .i_load_val (w_preset),
        .i_dec      (w_cnt_dec),
        .i_inc_min  (1'b0),
        .i_inc_sec  (1'b0),
        .o_val      (w_cnt),
        .o_zero_nxt (w_cnt_zero)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_cnt_load) w_state_nxt = ST_RUN;
                        else if (w_set) w_state_nxt = ST_SET_MIN;
            ST_SET_MIN: if (w_set) w_state_nxt = ST_SET_SEC;
            ST_SET_SEC: if (w_set) w_state_nxt = ST_IDLE;
            ST_RUN:     if (w_stop) w_state_nxt = ST_PAUSE;
                        else if (w_cnt_dec && w_cnt_zero) w_state_nxt = ST_DONE;
            ST_PAUSE:   if (w_stop) w_state_nxt = ST_IDLE;
                        else if (w_start) w_state_nxt = ST_RUN;
            ST_DONE:    if (w_stop || w_start) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Alarm stays up for ALARM_TICKS ticks spent in DONE, or until a button leaves DONE.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_alarm     <= 1'b0;
            r_alarm_cnt <= '0;
        end else if (r_state == ST_RUN && w_state_nxt == ST_DONE) begin
            r_alarm     <= 1'b1;
            r_alarm_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            if (w_state_nxt != ST_DONE) begin
                r_alarm <= 1'b0;
            end else if (TICK && r_alarm) begin
                r_alarm_cnt <= r_alarm_cnt + 8'd1;
                if (r_alarm_cnt == ALARM_LAST) r_alarm <= 1'b0;
            end
        end
    end

    always_comb begin
        TIME_BCD = '0;
        case (r_state)
            ST_IDLE, ST_SET_MIN, ST_SET_SEC: TIME_BCD = w_preset;
            ST_RUN, ST_PAUSE:                TIME_BCD = w_cnt;
            default:                         TIME_BCD = '0;
        endcase
    end

`ifdef COUNTDOWN_CTRL_BLINK_EN
    logic r_blink;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_blink <= 1'b0;
        end else if (w_state_nxt != r_state) begin
            r_blink <= 1'b0;
        end else if (TICK && (r_state == ST_SET_MIN || r_state == ST_SET_SEC ||
                              r_state == ST_PAUSE || r_state == ST_DONE)) begin
            r_blink <= ~r_blink;
        end
    end

    always_comb begin
        DIG_EN = 4'b1111;
        if (r_blink) begin
            case (r_state)
                ST_SET_MIN:        DIG_EN = 4'b0011;
                ST_SET_SEC:        DIG_EN = 4'b1100;
                ST_PAUSE, ST_DONE: DIG_EN = 4'b0000;
                default:           DIG_EN = 4'b1111;
            endcase
        end
    end
`else
    assign DIG_EN = 4'b1111;
`endif

    assign STATE = r_state;
    assign ALARM = r_alarm;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: directed scenarios then random buttons/ticks,
// every cycle compared against a seconds-based behavioural model.
module tb_countdown_ctrl;

    localparam int ALARM_TICKS = 10;
    localparam int S_IDLE = 0, S_SET_MIN = 1, S_SET_SEC = 2, S_RUN = 3, S_PAUSE = 4, S_DONE = 5;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        TICK = 1'b0;
    logic        BTN_START = 1'b0, BTN_STOP = 1'b0, BTN_SET = 1'b0, BTN_INC = 1'b0;
    logic [15:0] TIME_BCD;
    logic [3:0]  DIG_EN;
    logic [2:0]  STATE;
    logic        ALARM;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: times kept as total seconds
    int m_state, m_preset, m_cnt, m_alarm_ticks, m_blink;
    bit m_alarm;
    logic [15:0] exp_q[$];

    countdown_ctrl #(.DEFAULT_MIN(1), .DEFAULT_SEC(0), .ALARM_TICKS(ALARM_TICKS)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .TICK      (TICK),
        .BTN_START (BTN_START),
        .BTN_STOP  (BTN_STOP),
        .BTN_SET   (BTN_SET),
        .BTN_INC   (BTN_INC),
        .TIME_BCD  (TIME_BCD),
        .DIG_EN    (DIG_EN),
        .STATE     (STATE),
        .ALARM     (ALARM)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] secs_to_bcd(input int t);
        int mm, ss;
        mm = t / 60;
        ss = t % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] model_display();
        if (m_state == S_IDLE || m_state == S_SET_MIN || m_state == S_SET_SEC)
            return secs_to_bcd(m_preset);
        else if (m_state == S_RUN || m_state == S_PAUSE)
            return secs_to_bcd(m_cnt);
        return 16'h0000;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE;
        m_preset = 60;
        m_cnt = 60;
        m_alarm = 1'b0;
        m_alarm_ticks = 0;
        m_blink = 0;
        exp_q.push_back(model_display());
    endtask

    task automatic model_step(input bit tk, input bit st, input bit sp, input bit se, input bit in);
        bit e_start, e_set, e_inc;
        int prev;
        e_start = st && !sp;
        e_set   = se && !sp && !st;
        e_inc   = in && !sp && !st && !se;
        prev    = m_state;
        case (m_state)
            S_IDLE: begin
                if (e_start && m_preset != 0) begin
                    m_state = S_RUN;
                    m_cnt = m_preset;
                end else if (e_set) m_state = S_SET_MIN;
            end
            S_SET_MIN: begin
                if (e_set) m_state = S_SET_SEC;
                else if (e_inc) m_preset = ((m_preset / 60 + 1) % 60) * 60 + m_preset % 60;
            end
            S_SET_SEC: begin
                if (e_set) m_state = S_IDLE;
                else if (e_inc) m_preset = (m_preset / 60) * 60 + (m_preset % 60 + 1) % 60;
            end
            S_RUN: begin
                if (sp) m_state = S_PAUSE;
                else if (tk) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_state = S_DONE;
                        m_alarm = 1'b1;
                        m_alarm_ticks = 0;
                    end
                end
            end
            S_PAUSE: begin
                if (sp) m_state = S_IDLE;
                else if (e_start) m_state = S_RUN;
            end
            default: begin
                if (sp || e_start) begin
                    m_state = S_IDLE;
                    m_alarm = 1'b0;
                end else if (tk && m_alarm) begin
                    m_alarm_ticks++;
                    if (m_alarm_ticks >= ALARM_TICKS) m_alarm = 1'b0;
                end
            end
        endcase
        if (m_state != prev) m_blink = 0;
        else if (tk && (m_state == S_SET_MIN || m_state == S_SET_SEC ||
                        m_state == S_PAUSE || m_state == S_DONE)) m_blink = 1 - m_blink;
        exp_q.push_back(model_display());
    endtask

    function automatic logic [3:0] model_dig_en();
`ifdef COUNTDOWN_CTRL_BLINK_EN
        if (m_blink == 1) begin
            if (m_state == S_SET_MIN) return 4'b0011;
            if (m_state == S_SET_SEC) return 4'b1100;
            if (m_state == S_PAUSE || m_state == S_DONE) return 4'b0000;
        end
`endif
        return 4'b1111;
    endfunction

    task automatic check_all(input string tag);
        logic [15:0] exp_t;
        logic [3:0]  exp_d;
        exp_d = model_dig_en();
        exp_t = 16'h0000;
        if (exp_q.size() > 0) exp_t = exp_q.pop_front();
        n_tests++;
        assert (STATE === 3'(m_state)) else begin
            n_fail++;
            $error("FAIL %s state got %0d exp %0d", tag, STATE, m_state);
        end
        n_tests++;
        assert (TIME_BCD === exp_t) else begin
            n_fail++;
            $error("FAIL %s time_bcd got %h exp %h", tag, TIME_BCD, exp_t);
        end
        n_tests++;
        assert (ALARM === m_alarm) else begin
            n_fail++;
            $error("FAIL %s alarm got %b exp %b", tag, ALARM, m_alarm);
        end
        n_tests++;
        assert (DIG_EN === exp_d) else begin
            n_fail++;
            $error("FAIL %s dig_en got %b exp %b", tag, DIG_EN, exp_d);
        end
    endtask

    // One clock cycle: inputs driven at edge+1, model advanced at the edge, outputs checked at edge+1.
    task automatic cyc(input string tag, input bit tk, input bit st, input bit sp,
                       input bit se, input bit in);
        TICK = tk; BTN_START = st; BTN_STOP = sp; BTN_SET = se; BTN_INC = in;
        @(posedge CLK);
        model_step(tk, st, sp, se, in);
        #1;
        TICK = 1'b0; BTN_START = 1'b0; BTN_STOP = 1'b0; BTN_SET = 1'b0; BTN_INC = 1'b0;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges, checked before any clock edge.
    task automatic mid_cycle_reset(input string tag);
        #3;
        CLR = 1'b0;
        model_reset();
        #1;
        check_all({tag, "_async"});
        @(posedge CLK);
        #1;
        CLR = 1'b1;
        model_reset();
        check_all({tag, "_release"});
    endtask

    initial begin
        model_reset();
        @(posedge CLK);
        #1;
        check_all("reset");
        CLR = 1'b1;

        // default 01:00 countdown
        cyc("r033_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("r033_tick", 1, 0, 0, 0, 0);
        cyc("r033_stop", 0, 0, 1, 0, 0);
        cyc("r033_idle", 0, 0, 1, 0, 0);

        // set preset to 00:02 and run to expiry
        cyc("r034_set", 0, 0, 0, 1, 0);
        for (int i = 0; i < 59; i++) cyc("r034_incm", 0, 0, 0, 0, 1);
        cyc("r034_setsec", 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) cyc("r034_incs", 0, 0, 0, 0, 1);
        cyc("r034_setidle", 0, 0, 0, 1, 0);
        cyc("r034_start", 0, 1, 0, 0, 0);
        cyc("r034_tick1", 1, 0, 0, 0, 0);
        cyc("r034_tick2", 1, 0, 0, 0, 0);
        for (int i = 0; i < ALARM_TICKS + 2; i++) begin
            cyc("r034_gap", 0, 0, 0, 0, 0);
            cyc("r034_done_tick", 1, 0, 0, 0, 0);
        end
        cyc("r034_exit", 0, 1, 0, 0, 0);

        // button priority
        cyc("prio_start_set", 0, 1, 0, 1, 0);
        cyc("prio_stop_start", 0, 1, 1, 0, 0);
        cyc("prio_stop", 0, 0, 1, 0, 0);
        cyc("prio_set_inc", 0, 0, 0, 1, 1);
        cyc("prio_start_inc_setmin", 0, 1, 0, 0, 1);
        cyc("prio_set", 0, 0, 0, 1, 0);
        cyc("prio_set2", 0, 0, 0, 1, 0);

        // minute wrap, zero preset ignored, 00:03
        cyc("r035_set", 0, 0, 0, 1, 0);
        for (int i = 0; i < 60; i++) cyc("r035_incm", 0, 0, 0, 0, 1);
        cyc("r035_setsec", 0, 0, 0, 1, 0);
        for (int i = 0; i < 58; i++) cyc("r035_incs", 0, 0, 0, 0, 1);
        cyc("r035_idle0", 0, 0, 0, 1, 0);
        cyc("r035_start0", 0, 1, 0, 0, 0);
        cyc("r035_set2", 0, 0, 0, 1, 0);
        cyc("r035_set3", 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("r035_inc3", 0, 0, 0, 0, 1);
        cyc("r035_idle3", 0, 0, 0, 1, 0);

        // 00:30 run, stop vs tick, resume, double stop
        cyc("r036_set", 0, 0, 0, 1, 0);
        cyc("r036_setsec", 0, 0, 0, 1, 0);
        for (int i = 0; i < 27; i++) cyc("r036_incs", 0, 0, 0, 0, 1);
        cyc("r036_idle", 0, 0, 0, 1, 0);
        cyc("r036_start", 0, 1, 0, 0, 0);
        cyc("r036_stop_tick", 1, 0, 1, 0, 0);
        cyc("r036_resume", 0, 1, 0, 0, 0);
        cyc("r036_tick", 1, 0, 0, 0, 0);
        cyc("r036_stop1", 0, 0, 1, 0, 0);
        cyc("r036_stop2", 0, 0, 1, 0, 0);

        // mid-run async reset at 00:45, then pause blink
        mid_cycle_reset("r037_pre");
        cyc("r037_start", 0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) cyc("r037_tick", 1, 0, 0, 0, 0);
        mid_cycle_reset("r037_run");
        cyc("r037_restart", 0, 1, 0, 0, 0);
        cyc("r037_pause", 0, 0, 1, 0, 0);
        cyc("r037_blink1", 1, 0, 0, 0, 0);
        cyc("r037_blink2", 1, 0, 0, 0, 0);
        cyc("r037_idle", 0, 0, 1, 0, 0);

        // random buttons and ticks
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                mid_cycle_reset("rand_rst");
            end else begin
                cyc("rand",
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 19) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 4) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
